// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier: one partial product per clock, WIDTH iterations per result.
// Signed mode multiplies magnitudes and applies the sign to the final product.
module seq_multiplier #(
   parameter int unsigned WIDTH  = 4,
   parameter bit          SIGNED = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            busy_d, done_d;
   logic [PW-1:0]   mcand_q, acc_q, acc_sum;
   logic [WIDTH-1:0] mplier_q, mag_a, mag_b;
   logic [CW-1:0]   cnt_q;
   logic            neg_q, a_neg, b_neg, accept, last_iter;

   assign a_neg     = SIGNED && a[WIDTH-1];
   assign b_neg     = SIGNED && b[WIDTH-1];
   // Most-negative operand still fits as an unsigned WIDTH-bit magnitude.
   assign mag_a     = a_neg ? -a : a;
   assign mag_b     = b_neg ? -b : b;
   assign accept    = (state_q == IDLE) && start;
   assign last_iter = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
   assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

   // State and status register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   // Next-state and registered status decode.
   always_comb begin
      state_d = state_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_iter) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // Shift-add datapath; p only updates on the final iteration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         p        <= '0;
      end else if (accept) begin
         mcand_q  <= PW'(mag_a);
         mplier_q <= mag_b;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= a_neg ^ b_neg;
      end else if (state_q == RUN) begin
         acc_q    <= acc_sum;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (last_iter) p <= neg_q ? -acc_sum : acc_sum;
      end
   end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier across several WIDTH/SIGNED configurations.
module tb_seq_multiplier;

   logic clk, rst;
   logic s2, s4s, s4u, s8;
   logic [1:0] a2, b2;
   logic [3:0] a4s, b4s, a4u, b4u;
   logic [7:0] a8, b8;
   logic bz2, d2, bz4s, d4s, bz4u, d4u, bz8, d8;
   logic [3:0]  p2;
   logic [7:0]  p4s, p4u;
   logic [15:0] p8;
   int n_pass = 0;
   int n_chk  = 0;
   int n_fail = 0;

   seq_multiplier #(.WIDTH(2), .SIGNED(1'b0)) u_w2 (
      .clk(clk), .rst(rst), .start(s2), .a(a2), .b(b2), .busy(bz2), .done(d2), .p(p2));
   seq_multiplier #(.WIDTH(4), .SIGNED(1'b1)) u_w4s (
      .clk(clk), .rst(rst), .start(s4s), .a(a4s), .b(b4s), .busy(bz4s), .done(d4s), .p(p4s));
   seq_multiplier #(.WIDTH(4), .SIGNED(1'b0)) u_w4u (
      .clk(clk), .rst(rst), .start(s4u), .a(a4u), .b(b4u), .busy(bz4u), .done(d4u), .p(p4u));
   seq_multiplier #(.WIDTH(8), .SIGNED(1'b0)) u_w8 (
      .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .busy(bz8), .done(d8), .p(p8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mul4s(input string tag, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] e);
      s4s = 1'b1; a4s = x; b4s = y;
      tick();
      s4s = 1'b0; a4s = ~x; b4s = ~y;
      repeat (3) tick();
      check({tag, "_early"}, 64'(d4s), 64'(0));
      tick();
      check({tag, "_done"}, 64'({bz4s, d4s}), 64'(1));
      check({tag, "_p"}, 64'(p4s), 64'(e));
      tick();
   endtask

   task automatic mul8(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] e);
      s8 = 1'b1; a8 = x; b8 = y;
      tick();
      s8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      repeat (7) tick();
      check({tag, "_early"}, 64'(d8), 64'(0));
      tick();
      check({tag, "_done"}, 64'({bz8, d8}), 64'(1));
      check({tag, "_p"}, 64'(p8), 64'(e));
      tick();
   endtask

   initial begin
      logic [1:0] xa, xb;
      logic       seen;
      rst = 1'b0;
      s2 = 1'b0; s4s = 1'b0; s4u = 1'b0; s8 = 1'b0;
      a2 = '0; b2 = '0; a4s = '0; b4s = '0; a4u = '0; b4u = '0; a8 = '0; b8 = '0;
      #1 rst = 1'b1;
      #1;
      check("rst_w2",  64'({bz2, d2, p2}), 64'(0));
      check("rst_w4s", 64'({bz4s, d4s, p4s}), 64'(0));
      check("rst_w4u", 64'({bz4u, d4u, p4u}), 64'(0));
      check("rst_w8",  64'({bz8, d8, p8}), 64'(0));
      tick();
      tick();
      rst = 1'b0;
      tick();

      // 3*3 on WIDTH=2: busy for two cycles then a single done with p=9
      s2 = 1'b1; a2 = 2'd3; b2 = 2'd3;
      tick();
      s2 = 1'b0; a2 = 2'd0; b2 = 2'd1;
      check("w2_e0", 64'({bz2, d2}), 64'(2));
      tick();
      check("w2_e1", 64'({bz2, d2}), 64'(2));
      tick();
      check("w2_e2", 64'({bz2, d2}), 64'(1));
      check("w2_p9", 64'(p2), 64'(9));
      tick();
      check("w2_e3", 64'({bz2, d2, p2}), 64'(9));

      // All 16 unsigned pairs back to back, operands scrambled after acceptance
      for (int i = 0; i < 16; i++) begin
         xa = 2'(i >> 2);
         xb = 2'(i);
         s2 = 1'b1; a2 = xa; b2 = xb;
         tick();
         s2 = 1'b0; a2 = ~xa; b2 = ~xb;
         check("w2x_busy", 64'({bz2, d2}), 64'(2));
         tick();
         tick();
         check("w2x_done", 64'({bz2, d2}), 64'(1));
         check("w2x_p", 64'(p2), 64'({2'b00, xa} * {2'b00, xb}));
         tick();
         check("w2x_idle", 64'({bz2, d2}), 64'(0));
      end

      // Signed WIDTH=4 directed vectors
      mul4s("s_m8m8", 4'h8, 4'h8, 8'h40);
      mul4s("s_m8p7", 4'h8, 4'h7, 8'hC8);
      mul4s("s_0m5",  4'h0, 4'hB, 8'h00);
      mul4s("s_m1m1", 4'hF, 4'hF, 8'h01);
      mul4s("s_p7m1", 4'h7, 4'hF, 8'hF9);
      mul4s("s_p5m3", 4'h5, 4'hD, 8'hF1);
      mul4s("s_p7p7", 4'h7, 4'h7, 8'h31);

      // Start pulsed mid-RUN is dropped: single result 15*15
      s4u = 1'b1; a4u = 4'd15; b4u = 4'd15;
      tick();
      s4u = 1'b0;
      tick();
      check("ign_p_hold", 64'({bz4u, p4u}), 64'(9'h100));
      s4u = 1'b1; a4u = 4'd1; b4u = 4'd1;
      tick();
      s4u = 1'b0;
      check("ign_run", 64'({bz4u, d4u}), 64'(2));
      tick();
      tick();
      check("ign_done", 64'({bz4u, d4u}), 64'(1));
      check("ign_p", 64'(p4u), 64'(8'hE1));
      tick();
      check("ign_after1", 64'({bz4u, d4u}), 64'(0));
      tick();
      check("ign_after2", 64'({bz4u, d4u}), 64'(0));
      tick();
      check("ign_after3", 64'({bz4u, d4u, p4u}), 64'(8'hE1));

      // Start held high: a result every WIDTH+2 cycles
      s4u = 1'b1; a4u = 4'd5; b4u = 4'd6;
      for (int i = 1; i <= 13; i++) begin
         tick();
         check("hold_done", 64'(d4u), 64'((i == 5) || (i == 11)));
         check("hold_busy", 64'(bz4u),
               64'(((i >= 1) && (i <= 4)) || ((i >= 7) && (i <= 10)) || (i == 13)));
         if ((i == 5) || (i == 11)) check("hold_p", 64'(p4u), 64'(30));
      end
      s4u = 1'b0;

      // Reset mid-RUN aborts with no done, then a fresh start succeeds
      s8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
      tick();
      s8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
      repeat (3) tick();
      check("abort_run", 64'({bz8, d8}), 64'(2));
      rst = 1'b1;
      #1;
      check("abort_async", 64'({bz8, d8, p8}), 64'(0));
      tick();
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         tick();
         seen = seen | d8 | bz8;
      end
      check("abort_quiet", 64'({seen, p8}), 64'(0));
      mul8("w8_200x100", 8'd200, 8'd100, 16'h4E20);
      mul8("w8_255x255", 8'd255, 8'd255, 16'hFE01);
      mul8("w8_0x77",    8'd0,   8'd77,  16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
